// File: rtl/ring_sched_pkg.sv
// Shared encodings for the ring scheduler: source codes, FSM states and
// the chime beep clamp.
package ring_sched_pkg;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_TIMER = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;
  localparam logic [1:0] SRC_CHIME = 2'd3;

  localparam logic [3:0] CHIME_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_chime(input logic [3:0] cnt);
    logic [3:0] res;
    if (cnt > CHIME_MAX) begin
      res = CHIME_MAX;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_arbiter.sv
// Fixed-priority picker over the latched requests: alarm, then timer, then chime.
module ring_arbiter
  import ring_sched_pkg::*;
(
  input  logic [2:0] pending,
  output logic [2:0] grant,
  output logic [1:0] grant_src
);

  // priority select, pending bit order is {chime, alarm, timer}
  always_comb begin
    grant     = 3'b000;
    grant_src = SRC_NONE;
    if (pending[1]) begin
      grant     = 3'b010;
      grant_src = SRC_ALARM;
    end else if (pending[0]) begin
      grant     = 3'b001;
      grant_src = SRC_TIMER;
    end else if (pending[2]) begin
      grant     = 3'b100;
      grant_src = SRC_CHIME;
    end else begin
      grant     = 3'b000;
      grant_src = SRC_NONE;
    end
  end

endmodule

// File: rtl/ring_scheduler.sv
// Grants one alert source at a time and sequences its ring start pulse
// followed by the on/off buzzer cadence.
module ring_scheduler
  import ring_sched_pkg::*;
#(
  parameter int RING_PULSE  = 3,
  parameter int BEEP_ON     = 200,
  parameter int BEEP_OFF    = 300,
  parameter int TIMER_BEEPS = 20,
  parameter int ALARM_BEEPS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_timer,
  input  logic       req_alarm,
  input  logic       req_chime,
  input  logic [3:0] chime_count,
  input  logic       stop,
  output logic       ring,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] src,
  output logic [2:0] pending
);

  localparam int PH_MAX = (RING_PULSE > BEEP_ON)
                        ? ((RING_PULSE > BEEP_OFF) ? RING_PULSE : BEEP_OFF)
                        : ((BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF);
  localparam int PH_W = ($clog2(PH_MAX) < 1) ? 1 : $clog2(PH_MAX);
  localparam int BC_W = ($clog2(ALARM_BEEPS + 1) < 4) ? 4 : $clog2(ALARM_BEEPS + 1);

  localparam logic [PH_W-1:0] PH_ZERO  = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0] PH_PULSE = PH_W'(RING_PULSE - 1);
  localparam logic [PH_W-1:0] PH_ON    = PH_W'(BEEP_ON - 1);
  localparam logic [PH_W-1:0] PH_OFF   = PH_W'(BEEP_OFF - 1);
  localparam logic [BC_W-1:0] BC_ZERO  = BC_W'(0);
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
  localparam logic [BC_W-1:0] BC_TIMER = BC_W'(TIMER_BEEPS);
  localparam logic [BC_W-1:0] BC_ALARM = BC_W'(ALARM_BEEPS);

  state_t          state_r, state_s;
  logic [PH_W-1:0] ph_r, ph_s;
  logic [BC_W-1:0] bc_r, bc_s, grant_bc_s;
  logic [1:0]      src_r, src_s, gsrc_s;
  logic [2:0]      pend_r, pend_s, grant_s, clr_s;
  logic [3:0]      chime_r, chime_s;
  logic            ring_r, buzzer_r, busy_r;
  logic            preempt_s, acc_timer_s, acc_alarm_s, acc_chime_s;

  ring_arbiter u_arbiter (
    .pending   (pend_r),
    .grant     (grant_s),
    .grant_src (gsrc_s)
  );

  // beep count loaded with a grant from IDLE
  always_comb begin
    grant_bc_s = BC_ZERO;
    case (gsrc_s)
      SRC_TIMER: grant_bc_s = BC_TIMER;
      SRC_ALARM: grant_bc_s = BC_ALARM;
      SRC_CHIME: grant_bc_s = BC_W'(chime_r);
      default:   grant_bc_s = BC_ZERO;
    endcase
  end

  // request acceptance; a request for the source already in session is dropped
  always_comb begin
    acc_timer_s = req_timer & (src_r != SRC_TIMER);
    acc_alarm_s = req_alarm & (src_r != SRC_ALARM);
    acc_chime_s = req_chime & (chime_count != 4'd0) & (src_r != SRC_CHIME);
    pend_s      = (pend_r & ~clr_s) | {acc_chime_s, acc_alarm_s, acc_timer_s};
    chime_s     = acc_chime_s ? clamp_chime(chime_count) : chime_r;
  end

  // session sequencing: grant, preemption by alarm, stop, phase and beep countdown
  always_comb begin
    state_s   = state_r;
    ph_s      = ph_r;
    bc_s      = bc_r;
    src_s     = src_r;
    clr_s     = 3'b000;
    preempt_s = pend_r[1] & (src_r != SRC_ALARM);
    if (state_r == IDLE) begin
      if (|pend_r) begin
        state_s = PULSE;
        ph_s    = PH_PULSE;
        src_s   = gsrc_s;
        bc_s    = grant_bc_s;
        clr_s   = grant_s;
      end else begin
        state_s = IDLE;
      end
    end else if (preempt_s) begin
      // stop in the same cycle loses to the alarm
      state_s = PULSE;
      ph_s    = PH_PULSE;
      src_s   = SRC_ALARM;
      bc_s    = BC_ALARM;
      clr_s   = 3'b010;
    end else if (stop) begin
      state_s = IDLE;
      ph_s    = PH_ZERO;
      bc_s    = BC_ZERO;
      src_s   = SRC_NONE;
    end else begin
      case (state_r)
        PULSE: begin
          if (ph_r == PH_ZERO) begin
            state_s = ON;
            ph_s    = PH_ON;
          end else begin
            ph_s = ph_r - PH_ONE;
          end
        end
        ON: begin
          if (ph_r == PH_ZERO) begin
            state_s = OFF;
            ph_s    = PH_OFF;
          end else begin
            ph_s = ph_r - PH_ONE;
          end
        end
        OFF: begin
          if (ph_r != PH_ZERO) begin
            ph_s = ph_r - PH_ONE;
          end else if (bc_r == BC_ONE) begin
            state_s = IDLE;
            bc_s    = BC_ZERO;
            src_s   = SRC_NONE;
          end else begin
            state_s = ON;
            ph_s    = PH_ON;
            bc_s    = bc_r - BC_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          ph_s    = PH_ZERO;
          bc_s    = BC_ZERO;
          src_s   = SRC_NONE;
        end
      endcase
    end
  end

  // state, counters, latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ph_r     <= PH_ZERO;
      bc_r     <= BC_ZERO;
      src_r    <= SRC_NONE;
      pend_r   <= 3'b000;
      chime_r  <= 4'd0;
      ring_r   <= 1'b0;
      buzzer_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ph_r     <= ph_s;
      bc_r     <= bc_s;
      src_r    <= src_s;
      pend_r   <= pend_s;
      chime_r  <= chime_s;
      ring_r   <= (state_s == PULSE);
      buzzer_r <= (state_s == ON);
      busy_r   <= (state_s != IDLE);
    end
  end

  assign ring    = ring_r;
  assign buzzer  = buzzer_r;
  assign busy    = busy_r;
  assign src     = src_r;
  assign pending = pend_r;

endmodule

// File: tb/tb_ring_scheduler.sv
// Directed bench for ring_scheduler: a session-level reference model is
// checked every cycle, and pinned by literal expectations at key cycles.
module tb_ring_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_timer, req_alarm, req_chime, stop;
  logic [3:0] chime_count;
  logic       ring, buzzer, busy;
  logic [1:0] src;
  logic [2:0] pending;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int base;

  // reference model: a session is (source, first cycle, beep count)
  logic [2:0] m_pend;
  int         m_chime, m_src, m_start, m_beeps;
  bit         m_active;
  logic       e_ring, e_buzzer, e_busy;
  logic [1:0] e_src;

  always #5 clk = ~clk;

  ring_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .req_timer   (req_timer),
    .req_alarm   (req_alarm),
    .req_chime   (req_chime),
    .chime_count (chime_count),
    .stop        (stop),
    .ring        (ring),
    .buzzer      (buzzer),
    .busy        (busy),
    .src         (src),
    .pending     (pending)
  );

  task automatic grant(input int s, input int c);
    m_active = 1'b1;
    m_src    = s;
    m_start  = c;
    m_beeps  = (s == 1) ? 20 : ((s == 2) ? 120 : m_chime);
  endtask

  task automatic model_edge();
    int c, off, len, cur;
    logic [2:0] p;
    c = cyc + 1;
    if (reset) begin
      m_pend = 3'b000; m_chime = 0; m_active = 1'b0; m_src = 0;
    end else begin
      cur = m_active ? m_src : 0;
      p   = m_pend;
      if (m_active) begin
        off = cyc - m_start;
        len = 3 + 500 * m_beeps;
        if (p[1] && m_src != 2) begin
          grant(2, c); m_pend[1] = 1'b0;
        end else if (stop) begin
          m_active = 1'b0;
        end else if (off == len - 1) begin
          m_active = 1'b0;
        end
      end else if (p[1]) begin
        grant(2, c); m_pend[1] = 1'b0;
      end else if (p[0]) begin
        grant(1, c); m_pend[0] = 1'b0;
      end else if (p[2]) begin
        grant(3, c); m_pend[2] = 1'b0;
      end
      if (req_timer && cur != 1) m_pend[0] = 1'b1;
      if (req_alarm && cur != 2) m_pend[1] = 1'b1;
      if (req_chime && chime_count != 4'd0 && cur != 3) begin
        m_pend[2] = 1'b1;
        m_chime   = (chime_count > 4'd12) ? 12 : int'(chime_count);
      end
    end
    off      = c - m_start;
    e_busy   = m_active;
    e_ring   = m_active && off < 3;
    e_buzzer = m_active && off >= 3 && ((off - 3) % 500) < 200;
    e_src    = m_active ? 2'(m_src) : 2'd0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    ntests++;
    if (ring !== e_ring || buzzer !== e_buzzer || busy !== e_busy ||
        src !== e_src || pending !== m_pend) begin
      nfail++;
      $display("FAIL model cyc=%0d got ring=%b buzzer=%b busy=%b src=%0d pending=%b want ring=%b buzzer=%b busy=%b src=%0d pending=%b",
               cyc, ring, buzzer, busy, src, pending, e_ring, e_buzzer, e_busy, e_src, m_pend);
    end
    req_timer = 1'b0; req_alarm = 1'b0; req_chime = 1'b0; stop = 1'b0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_timer = 1'b0; req_alarm = 1'b0; req_chime = 1'b0;
    stop = 1'b0; chime_count = 4'd0;
    m_pend = 3'b000; m_chime = 0; m_active = 1'b0; m_src = 0; m_start = 0; m_beeps = 0;
    goto(3);
    chk("reset_busy", {2'b00, busy}, 3'b000);
    chk("reset_outs", {ring, buzzer, 1'b0}, 3'b000);
    chk("reset_src", {1'b0, src}, 3'b000);
    chk("reset_pending", pending, 3'b000);
    reset = 1'b0;
    goto(5);

    // timer and chime(15 -> 12) together: timer first, chime after one idle cycle
    base = cyc;
    req_timer = 1'b1; req_chime = 1'b1; chime_count = 4'd15;
    goto(base + 1);     chk("sim_pending", pending, 3'b101);
    goto(base + 2);     chk("timer_ring_on", {2'b00, ring}, 3'b001);
    chk("timer_src", {1'b0, src}, 3'b001);
    chk("sim_pending_run", pending, 3'b100);
    goto(base + 4);     chk("timer_ring_last", {2'b00, ring}, 3'b001);
    goto(base + 5);     chk("timer_beep0", {1'b0, ring, buzzer}, 3'b001);
    goto(base + 204);   chk("timer_beep0_end", {2'b00, buzzer}, 3'b001);
    goto(base + 205);   chk("timer_off0", {2'b00, buzzer}, 3'b000);
    goto(base + 505);   chk("timer_beep1", {2'b00, buzzer}, 3'b001);
    goto(base + 10004); chk("timer_busy_last", {2'b00, busy}, 3'b001);
    goto(base + 10005); chk("timer_busy_fall", {2'b00, busy}, 3'b000);
    goto(base + 10006); chk("chime_ring", {ring, src}, 3'b111);
    goto(base + 10008); chk("chime_ring_last", {2'b00, ring}, 3'b001);
    goto(base + 10009); chk("chime_ring_off", {2'b00, ring}, 3'b000);
    goto(base + 15509); chk("chime12_last_beep", {2'b00, buzzer}, 3'b001);
    goto(base + 16008); chk("chime12_busy", {2'b00, busy}, 3'b001);
    goto(base + 16009); chk("chime12_done", {2'b00, busy}, 3'b000);

    // chime of 3 beeps, then a zero-count chime that must be ignored
    goto(cyc + 2);
    base = cyc;
    req_chime = 1'b1; chime_count = 4'd3;
    goto(base + 505);   chk("chime3_beep1", {2'b00, buzzer}, 3'b001);
    goto(base + 1005);  chk("chime3_beep2", {2'b00, buzzer}, 3'b001);
    goto(base + 1204);  chk("chime3_beep2_end", {2'b00, buzzer}, 3'b001);
    goto(base + 1205);  chk("chime3_beep2_off", {2'b00, buzzer}, 3'b000);
    goto(base + 1505);  chk("chime3_done", {2'b00, busy}, 3'b000);
    base = cyc;
    req_chime = 1'b1; chime_count = 4'd0;
    goto(base + 1);     chk("chime0_pending", pending, 3'b000);
    goto(base + 2);     chk("chime0_busy", {2'b00, busy}, 3'b000);

    // alarm preempts a timer session; repeat requests for the active source drop
    goto(cyc + 2);
    base = cyc;
    req_timer = 1'b1;
    goto(base + 500);   req_timer = 1'b1;
    goto(base + 501);   chk("timer_repeat_drop", pending, 3'b000);
    goto(base + 1000);  req_alarm = 1'b1;
    goto(base + 1001);  chk("alarm_pending", pending, 3'b010);
    goto(base + 1002);  chk("alarm_ring", {ring, src}, 3'b110);
    chk("alarm_buzz_low", {2'b00, buzzer}, 3'b000);
    goto(base + 1004);  chk("alarm_ring_last", {2'b00, ring}, 3'b001);
    goto(base + 2000);  req_alarm = 1'b1;
    goto(base + 2001);  chk("alarm_repeat_drop", pending, 3'b000);
    goto(base + 61004); chk("alarm_busy_last", {2'b00, busy}, 3'b001);
    goto(base + 61005); chk("alarm_done", {busy, src}, 3'b000);
    goto(base + 61008); chk("timer_not_resumed", {busy, src}, 3'b000);

    // stop during a timer session keeps the pending chime
    goto(cyc + 2);
    base = cyc;
    req_timer = 1'b1;
    goto(base + 100);   req_chime = 1'b1; chime_count = 4'd1;
    goto(base + 300);   stop = 1'b1;
    goto(base + 301);   chk("stop_idle", {busy, buzzer, ring}, 3'b000);
    chk("stop_keeps_chime", pending, 3'b100);
    goto(base + 302);   chk("stop_chime_grant", {ring, src}, 3'b111);
    goto(base + 805);   chk("stop_chime_done", {2'b00, busy}, 3'b000);
    stop = 1'b1;
    goto(base + 806);   chk("stop_in_idle", {busy, src}, 3'b000);

    // reset mid alarm session, then a normal request
    goto(cyc + 2);
    base = cyc;
    req_alarm = 1'b1;
    goto(base + 10);    req_timer = 1'b1;
    goto(base + 11);    chk("pre_reset_pending", pending, 3'b001);
    goto(base + 700);   reset = 1'b1;
    goto(base + 701);   chk("reset_mid_outs", {busy, buzzer, ring}, 3'b000);
    chk("reset_mid_src", {1'b0, src}, 3'b000);
    chk("reset_mid_pending", pending, 3'b000);
    reset = 1'b0;
    goto(base + 705);   req_timer = 1'b1;
    goto(base + 706);   chk("post_reset_pending", pending, 3'b001);
    goto(base + 707);   chk("post_reset_grant", {busy, src}, 3'b101);
    goto(base + 720);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
